sram_master: RTL and testbench
==============================

// Module: sram_master
// PURPOSE
// - Initiator side of the 32-bit byte-write SRAM port (CS/OE/WEB[3:0]/A/DI/DO).
// - Converts pipeline load/store requests into SRAM cycles.
// - Handles byte-lane enables, store-data replication, load alignment and sign extension.
// - Sits between the MEM stage / LSU and the data SRAM; one request in flight.
// PARAMETERS
// - AW         14            SRAM word-address width; byte address bits [AW+1:2] drive A
// - BASE_ADDR  32'h0000_0000 region base; compared only when the range check is compiled in
// PORTS
// - clk          in   1   single clock; SRAM CK is tied to the same clk
// - rst          in   1   synchronous, active-high reset
// - req_valid    in   1   request present
// - req_ready    out  1   controller can accept; high only in IDLE
// - req_we       in   1   1 = store, 0 = load
// - req_size     in   2   0 = byte, 1 = half, 2 = word; 3 is treated as an error
// - req_unsigned in   1   load zero-extends (LBU/LHU) when 1
// - req_addr     in   32  byte address
// - req_wdata    in   32  store data, right-justified
// - rsp_valid    out  1   one-cycle response pulse
// - rsp_rdata    out  32  aligned and extended load data; 0 for stores and errors
// - rsp_err      out  1   misaligned / illegal size (/ out of range), valid with rsp_valid
// - sram_cs      out  1   chip select
// - sram_oe      out  1   output enable
// - sram_web     out  4   active-low byte write enables; bit k = byte lane k
// - sram_a       out  AW  word address
// - sram_di      out  32  write data
// - sram_do      in   32  read data; valid in the cycle after the CS cycle
// BEHAVIOUR
// - Reset: all outputs are reset to these values; FSM goes to IDLE.
//   - sram_cs=0, sram_oe=0, sram_web=4'hF, sram_a=0, sram_di=0
//   - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 (IDLE)
// - All sram_* outputs are registered.
// - FSM states: IDLE, ACCESS, READ, RESP.
// - IDLE: accept on req_valid & req_ready; latch the request.
//   - Legal request: load sram_a, sram_di and sram_web, set sram_cs=1, go to ACCESS.
//   - Error request: no SRAM cycle; go to RESP with err=1.
// - ACCESS (sram_cs=1 for exactly one cycle):
//   - store -> RESP
//   - load -> READ, with sram_oe=1 and sram_cs=0
// - READ: at the edge, capture sram_do, select the lane by addr[1:0], extend into rsp_rdata, go to RESP.
// - RESP: rsp_valid=1 for one cycle, then IDLE; all sram_* outputs return to idle values.
// - Latency from accept edge to rsp_valid: load 3 cycles, store 2 cycles, error 1 cycle.
// - Back-to-back requests: the next accept happens one cycle after RESP, in IDLE.
// - Lane encoding (sram_web / sram_di):
//   - byte @ offset k: web bit k = 0, others 1; di = {4{wdata[7:0]}}
//   - half @ 0: web = 4'b1100; half @ 2: web = 4'b0011; di = {2{wdata[15:0]}}
//   - word: web = 4'b0000; di = wdata
//   - load: web = 4'b1111
// - Misaligned requests: half with addr[0]=1, word with addr[1:0]!=0, or size=3 -> err.
// - Load extraction:
//   - byte = do[8*off +: 8]; half = do[16*addr[1] +: 16]
//   - sign-extend from bit 7 / bit 15 unless req_unsigned
// - Address: A = addr[AW+1:2]. Without the range check, upper bits are ignored (aliasing).
// - req_* inputs are ignored outside IDLE. The latched copy is used; inputs need not be held.
// - Reset mid-operation:
//   - rst during ACCESS: the SRAM still sees that CS edge, so a store commits; no rsp_valid is produced.
//   - rst at the accept edge: nothing is issued.
// CONFIGURATION
// - SRAM_MASTER_RANGE_CHECK_EN defined:
//   - addr[31:AW+2] != BASE_ADDR[31:AW+2] -> err, no SRAM cycle, 1-cycle error latency.
// - SRAM_MASTER_RANGE_CHECK_EN undefined:
//   - no range compare; out-of-region addresses alias into the SRAM; BASE_ADDR is unused.
// TESTING
// - SW 0x12345678 @0x10, then LW @0x10:
//   - store: cs=1 with web=0000 and a=4; rsp_valid 2 cycles after accept
//   - load: rsp_rdata=0x12345678, rsp_valid 3 cycles after accept
// - SB 0xAB @0x13 (web=0111, di=0xABABABAB), then loads @0x13:
//   - LB -> 0xFFFFFFAB
//   - LBU -> 0x000000AB
//   - the other three bytes of the word are unchanged
// - SH 0x8001 @0x22 (web=0011), then halfword loads @0x22:
//   - LH -> 0xFFFF8001
//   - LHU -> 0x00008001
// - LW @0x11 and SH @0x21:
//   - cs never asserts; rsp_err=1, rsp_rdata=0; rsp_valid 1 cycle after accept
// - rst asserted during ACCESS of SW 0xDEADBEEF @0x40:
//   - no rsp_valid; outputs reach reset values on the next edge
//   - a later LW @0x40 returns 0xDEADBEEF
// - With SRAM_MASTER_RANGE_CHECK_EN and BASE_ADDR=0:
//   - LW @0x0001_0000 -> rsp_err=1 and no CS
//   - without the macro: access to word 0

Source files
------------

// File: rtl/sram_master.sv
// Load/store initiator for a 32-bit byte-writable synchronous SRAM: one request in flight.
// Define SRAM_MASTER_RANGE_CHECK_EN to reject addresses outside the BASE_ADDR region.
module sram_master #(
    parameter int          AW        = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          sram_cs,
    output logic          sram_oe,
    output logic [3:0]    sram_web,
    output logic [AW-1:0] sram_a,
    output logic [31:0]   sram_di,
    input  logic [31:0]   sram_do
);
    typedef enum logic [1:0] {IDLE, ACCESS, READ, RESP} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;
    logic          cs_q, cs_d;
    logic          oe_q, oe_d;
    logic [3:0]    web_q, web_d;
    logic [AW-1:0] a_q, a_d;
    logic [31:0]   di_q, di_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic          misaligned, range_err, req_err;
    logic [3:0]    lane_web;
    logic [31:0]   lane_di;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    assign misaligned = (req_size == 2'd3)
                      | ((req_size == 2'd1) & req_addr[0])
                      | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

`ifdef SRAM_MASTER_RANGE_CHECK_EN
    assign range_err = (req_addr[31:AW+2] != BASE_ADDR[31:AW+2]);
`else
    // Upper address bits alias into the SRAM; sink them to keep lint quiet.
    logic unused_range_bits;
    assign unused_range_bits = ^{BASE_ADDR, req_addr[31:AW+2]};
    assign range_err = 1'b0;
`endif

    assign req_err = misaligned | range_err;

    always_comb begin
        lane_web = 4'b0000;
        lane_di  = req_wdata;
        case (req_size)
            2'd0: begin
                lane_web = ~(4'b0001 << req_addr[1:0]);
                lane_di  = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                lane_web = req_addr[1] ? 4'b0011 : 4'b1100;
                lane_di  = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = sram_do[{off_q, 3'b000} +: 8];
    assign ld_half = sram_do[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'd0:    ld_data = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            2'd1:    ld_data = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: ld_data = sram_do;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        cs_d        = cs_q;
        oe_d        = oe_q;
        web_d       = web_q;
        a_d         = a_q;
        di_d        = di_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    off_d  = req_addr[1:0];
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        state_d = ACCESS;
                        cs_d    = 1'b1;
                        a_d     = req_addr[AW+1:2];
                        web_d   = req_we ? lane_web : 4'hF;
                        di_d    = req_we ? lane_di : 32'h0;
                    end
                end
            end
            ACCESS: begin
                cs_d  = 1'b0;
                web_d = 4'hF;
                if (we_q) begin
                    state_d     = RESP;
                    a_d         = '0;
                    di_d        = 32'h0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'h0;
                end else begin
                    state_d = READ;
                    oe_d    = 1'b1;
                end
            end
            READ: begin
                // SRAM data for the CS cycle is on sram_do now.
                state_d     = RESP;
                oe_d        = 1'b0;
                a_d         = '0;
                di_d        = 32'h0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = ld_data;
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            off_q       <= 2'd0;
            cs_q        <= 1'b0;
            oe_q        <= 1'b0;
            web_q       <= 4'hF;
            a_q         <= '0;
            di_q        <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            cs_q        <= cs_d;
            oe_q        <= oe_d;
            web_q       <= web_d;
            a_q         <= a_d;
            di_q        <= di_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign sram_cs   = cs_q;
    assign sram_oe   = oe_q;
    assign sram_web  = web_q;
    assign sram_a    = a_q;
    assign sram_di   = di_q;

endmodule

// File: tb/tb_sram_master.sv
// Bench for sram_master: directed table, reset corner cases, then random traffic
// checked against a byte-array memory model.
module tb_sram_master;
    localparam int          AW   = 14;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          sram_cs;
    logic          sram_oe;
    logic [3:0]    sram_web;
    logic [AW-1:0] sram_a;
    logic [31:0]   sram_di;
    logic [31:0]   sram_do;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_master #(.AW(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .sram_cs(sram_cs), .sram_oe(sram_oe),
        .sram_web(sram_web), .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
    );

    // Synchronous SRAM: lane writes and registered read on a CS edge.
    logic [31:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_cs) begin
            for (int k = 0; k < 4; k++)
                if (!sram_web[k]) sram_mem[sram_a][8*k +: 8] <= sram_di[8*k +: 8];
            sram_do <= sram_mem[sram_a];
        end
    end

    // Reference memory as a flat little-endian byte array.
    logic [7:0] ref_mem [0:(4<<AW)-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic [3:0] web, output logic [31:0] di);
        int nb, base, mask;
        logic [63:0] v;
        nb    = (size == 2'd3) ? 4 : (1 << size);
        err   = (size == 2'd3) || ((addr % nb) != 0);
`ifdef SRAM_MASTER_RANGE_CHECK_EN
        if ((addr >> (AW+2)) != (BASE >> (AW+2))) err = 1'b1;
`endif
        base  = int'(addr[AW+1:0]);
        rdata = 32'h0;
        web   = 4'hF;
        di    = 32'h0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            lat  = 2;
            mask = ~(((1 << nb) - 1) << (base % 4));
            web  = mask[3:0];
            for (int i = 0; i < nb; i++) ref_mem[base+i] = wdata[8*i +: 8];
            for (int i = 0; i < 4; i++) di[8*i +: 8] = wdata[8*(i % nb) +: 8];
        end else begin
            lat = 3;
            v = 64'h0;
            for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[base+i]) << (8*i));
            if (!uns && v[8*nb-1]) v = v | (~64'h0 << (8*nb));
            rdata = v[31:0];
        end
    endtask

    // Issue one request and observe it until rsp_valid or a cycle budget expires.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output logic cs_seen, output logic oe_seen, output logic rdy,
                           output logic [3:0] web, output logic [AW-1:0] a,
                           output logic [31:0] di, output logic got);
        @(negedge clk);
        rdy = req_ready;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = $urandom_range(0, 1) == 1; req_we = $urandom_range(0, 1) == 1;
        req_size = 2'($urandom); req_unsigned = $urandom_range(0, 1) == 1;
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; got = 1'b0; cs_seen = 1'b0; oe_seen = 1'b0;
        rdata = 32'h0; err = 1'b0; web = 4'hF; a = '0; di = 32'h0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (sram_cs) begin
                cs_seen = 1'b1; web = sram_web; a = sram_a; di = sram_di;
            end
            if (sram_oe) oe_seen = 1'b1;
            if (rsp_valid) begin
                got = 1'b1; rdata = rsp_rdata; err = rsp_err;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic do_and_check(input int idx, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat,
                                input logic [3:0] exp_web, input logic [31:0] exp_di);
        logic [31:0] rdata, di;
        logic err, cs_seen, oe_seen, rdy, got;
        logic [3:0] web;
        logic [AW-1:0] a;
        int lat;
        run_txn(we, size, uns, addr, wdata, rdata, err, lat, cs_seen, oe_seen, rdy, web, a, di, got);
        $display("[TB] txn %0d we=%0d size=%0d uns=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
                 idx, we, size, uns, addr, wdata, rdata, err, lat);
        check("ready", {31'h0, rdy}, 32'h1);
        check("rsp_seen", {31'h0, got}, 32'h1);
        check("latency", lat, exp_lat);
        check("rsp_err", {31'h0, err}, {31'h0, exp_err});
        check("rsp_rdata", rdata, exp_rdata);
        check("cs_seen", {31'h0, cs_seen}, {31'h0, !exp_err});
        check("oe_seen", {31'h0, oe_seen}, {31'h0, !exp_err && !we});
        if (!exp_err) begin
            check("sram_web", {28'h0, web}, {28'h0, exp_web});
            check("sram_a", {{(32-AW){1'b0}}, a}, {{(32-AW){1'b0}}, addr[AW+1:2]});
            if (we) check("sram_di", di, exp_di);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_web;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] m_rdata, m_di;
        logic m_err, seen;
        logic [3:0] m_web;
        int m_lat;

        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 32'h0;
        for (int i = 0; i < (4 << AW); i++) ref_mem[i] = 8'h0;

        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 32'h0,        1'b0, 2, 4'b0000});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h12345678, 1'b0, 3, 4'b1111});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 32'h0,        1'b0, 2, 4'b0111});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFFAB, 1'b0, 3, 4'b1111});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h000000AB, 1'b0, 3, 4'b1111});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hAB345678, 1'b0, 3, 4'b1111});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 32'h0,        1'b0, 2, 4'b0011});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 3, 4'b1111});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        32'h00008001, 1'b0, 3, 4'b1111});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h20, 32'hCAFE1234, 32'h0,        1'b0, 2, 4'b1100});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h80011234, 1'b0, 3, 4'b1111});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1, 4'b1111});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h21, 32'h5555,     32'h0,        1'b1, 1, 4'b1111});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h20, 32'h0,        32'h0,        1'b1, 1, 4'b1111});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0,  32'hA5A50F0F, 32'h0,        1'b0, 2, 4'b0000});
`ifdef SRAM_MASTER_RANGE_CHECK_EN
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0, 32'h0,        1'b1, 1, 4'b1111});
`else
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0, 32'hA5A50F0F, 1'b0, 3, 4'b1111});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", {31'h0, sram_cs}, 32'h0);
        check("rst_oe", {31'h0, sram_oe}, 32'h0);
        check("rst_web", {28'h0, sram_web}, 32'hF);
        check("rst_a", {{(32-AW){1'b0}}, sram_a}, 32'h0);
        check("rst_di", sram_di, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            // Keep the reference memory in step; table values are the expectations.
            model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  m_rdata, m_err, m_lat, m_web, m_di);
            do_and_check(i, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                         vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_web, m_di);
        end

        // Reset during ACCESS of SW 0xDEADBEEF @0x40: store lands, no response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstacc_cs", {31'h0, sram_cs}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstacc_cs_after", {31'h0, sram_cs}, 32'h0);
        check("rstacc_web_after", {28'h0, sram_web}, 32'hF);
        check("rstacc_di_after", sram_di, 32'h0);
        check("rstacc_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("rstacc_no_rsp", {31'h0, seen}, 32'h0);
        $display("[TB] txn rst-in-ACCESS SW DEADBEEF @40 rsp_seen=%0d", seen);
        model(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, m_rdata, m_err, m_lat, m_web, m_di);

        // Reset on the accept edge of SW 0x11111111 @0x40: nothing issued.
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'h11111111;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || sram_cs) seen = 1'b1;
        end
        check("rstacc_edge_idle", {31'h0, seen}, 32'h0);
        $display("[TB] txn rst-at-accept SW 11111111 @40 activity=%0d", seen);
        do_and_check(100, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 3, 4'hF, 32'h0);

        for (int i = 0; i < 150; i++) begin
            logic we, uns;
            logic [1:0] size;
            logic [31:0] addr, wdata;
            int s;
            we    = $urandom_range(0, 1) == 1;
            uns   = $urandom_range(0, 1) == 1;
            s     = $urandom_range(0, 7);
            size  = (s < 7) ? 2'(s % 3) : 2'd3;
            addr  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & 32'hFFFF_0000);
            wdata = $urandom;
            model(we, size, uns, addr, wdata, m_rdata, m_err, m_lat, m_web, m_di);
            do_and_check(200 + i, we, size, uns, addr, wdata, m_rdata, m_err, m_lat, m_web, m_di);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
